seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/display_pkg.sv | 24 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg_scan_display.sv | 122 ++++++++++++
 tb/tb_seg_scan_display.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scanner: segment bit positions and the hex decode table.
// Purely declarative, no logic and no latency.
// No flow control; consumers index the table combinationally.
package display_pkg;

  // Bit positions inside the 8-bit indicator bus ({dp,g,f,e,d,c,b,a})
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high gfedcba patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-high gfedcba segment pattern.
// Combinational, zero latency.
// No flow control; polarity and blanking are handled by the caller.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[value];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment driver: digit storage, slot prescaler, guard band, leading-zero blanking.
// Outputs registered one cycle after prescaler/scan_index/storage; writes show on the second cycle.
// No backpressure: writes are accepted every cycle, out-of-range indices are dropped.
module seg_scan_display
  import display_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0,
  localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3:0]        wr_value,
  input  logic              wr_dp,
  input  logic              clear,
  input  logic              blank_lz,
  output logic [7:0]        indicator,
  output logic [DIGITS-1:0] indicator_choice,
  output logic [IDX_W-1:0]  scan_index,
  output logic              frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [7:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [3:0]        val_q [DIGITS];
  logic              dp_q  [DIGITS];
  logic [PW-1:0]     presc;
  logic              presc_wrap;
  logic              last_digit;
  logic              in_guard;
  logic [DIGITS-1:0] lz_blank;
  logic              zero_run;
  logic [3:0]        cur_val;
  logic              cur_dp;
  logic              cur_blank;
  logic [6:0]        cur_seg;
  logic [7:0]        nxt_ind;
  logic [DIGITS-1:0] nxt_sel;

  assign presc_wrap = (presc == PW'(SCAN_DIV - 1));
  assign last_digit = (scan_index == IDX_W'(DIGITS - 1));
  assign in_guard   = (int'(presc) < GUARD);

  // Digit registers: reset and clear wipe everything, otherwise one in-range entry is written
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (reset || clear) begin
        val_q[i] <= 4'd0;
        dp_q[i]  <= 1'b0;
      end else if (wr_en && (int'(wr_index) == i)) begin
        val_q[i] <= wr_value;
        dp_q[i]  <= wr_dp;
      end
    end
  end

  // Slot prescaler and digit scan counter; frame_tick marks the wrap back to digit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      scan_index <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= presc_wrap && last_digit;
      if (presc_wrap) begin
        presc      <= '0;
        scan_index <= last_digit ? '0 : scan_index + IDX_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Leading-zero mask: a digit blanks when it and every higher digit hold zero (never digit 0)
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (val_q[k] == 4'd0);
      lz_blank[k] = blank_lz && (k != 0) && zero_run;
    end
  end

  assign cur_val   = val_q[scan_index];
  assign cur_dp    = dp_q[scan_index];
  assign cur_blank = lz_blank[scan_index];

  hex_to_seg7 u_dec (
    .value (cur_val),
    .seg   (cur_seg)
  );

  // Next indicator/select pair for the current slot, both taken from the same digit
  always_comb begin
    nxt_ind = 8'h00;
    nxt_sel = '0;
    if (!in_guard) begin
      nxt_sel         = DIGITS'(1) << scan_index;
      nxt_ind[6:0]    = cur_blank ? SEG_OFF : cur_seg;
      nxt_ind[SEG_DP] = cur_dp;
    end
  end

  // Output registers with polarity applied; reset forces everything to the inactive level
  always_ff @(posedge clk) begin
    if (reset) begin
      indicator        <= SEG_INV;
      indicator_choice <= SEL_INV;
    end else begin
      indicator        <= nxt_ind ^ SEG_INV;
      indicator_choice <= nxt_sel ^ SEL_INV;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench: a cycle-count reference model pushes expected outputs, a negedge monitor pops and compares.
// Three DUTs share inputs: 4-digit, 4-digit inverted polarity, and 3-digit with no guard.
// Directed scenarios first, then randomized writes/clears/blanking/resets.
module tb_seg_scan_display;

  typedef struct packed {
    logic [7:0] ind;
    logic [7:0] ch;
    logic [2:0] sc;
    logic       ft;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t c;
  } qe_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_index;
  logic [3:0] wr_value;
  logic       wr_dp;
  logic       clear;
  logic       blank_lz;

  logic [7:0] ind_a, ind_b, ind_c;
  logic [3:0] ch_a, ch_b;
  logic [2:0] ch_c;
  logic [1:0] sc_a, sc_b, sc_c;
  logic       ft_a, ft_b, ft_c;

  int tests = 0;
  int fails = 0;
  int n_edges = 0;
  logic [7:0][4:0] st_a = '0;
  logic [7:0][4:0] st_c = '0;
  qe_t q [$];

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_value(wr_value),
    .wr_dp(wr_dp), .clear(clear), .blank_lz(blank_lz),
    .indicator(ind_a), .indicator_choice(ch_a), .scan_index(sc_a), .frame_tick(ft_a));

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_value(wr_value),
    .wr_dp(wr_dp), .clear(clear), .blank_lz(blank_lz),
    .indicator(ind_b), .indicator_choice(ch_b), .scan_index(sc_b), .frame_tick(ft_b));

  seg_scan_display #(.DIGITS(3), .SCAN_DIV(3), .GUARD(0), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_c (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_value(wr_value),
    .wr_dp(wr_dp), .clear(clear), .blank_lz(blank_lz),
    .indicator(ind_c), .indicator_choice(ch_c), .scan_index(sc_c), .frame_tick(ft_c));

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Outputs after an edge, given n non-reset edges already elapsed and the pre-edge storage
  function automatic exp_t model_out(input int nd, input int sd, input int gd, input int n,
                                     input logic [7:0][4:0] stp, input logic blz, input logic rst);
    exp_t e;
    int p, d;
    logic blank;
    e = '0;
    if (rst) return e;
    p = n % sd;
    d = (n / sd) % nd;
    if (p >= gd) begin
      e.ch = 8'(1 << d);
      blank = blz && (d > 0);
      for (int j = d; j < nd; j++)
        if (stp[j][4:1] != 4'd0) blank = 1'b0;
      e.ind[7]   = stp[d][0];
      e.ind[6:0] = blank ? 7'h00 : hex7(stp[d][4:1]);
    end
    e.sc = 3'(((n + 1) / sd) % nd);
    e.ft = ((n + 1) % (sd * nd)) == 0;
    return e;
  endfunction

  function automatic logic [7:0][4:0] model_store(input int nd, input logic [7:0][4:0] stp,
                                                  input logic rst, input logic clr, input logic we,
                                                  input int idx, input logic [3:0] v, input logic dp);
    logic [7:0][4:0] r;
    r = stp;
    if (rst || clr) r = '0;
    else if (we && idx < nd) r[idx] = {v, dp};
    return r;
  endfunction

  // Reference model: predicts every clock edge and queues the expectation
  always @(posedge clk) begin
    qe_t e;
    e.a = model_out(4, 4, 1, n_edges, st_a, blank_lz, reset);
    e.c = model_out(3, 3, 0, n_edges, st_c, blank_lz, reset);
    st_a = model_store(4, st_a, reset, clear, wr_en, int'(wr_index), wr_value, wr_dp);
    st_c = model_store(3, st_c, reset, clear, wr_en, int'(wr_index), wr_value, wr_dp);
    n_edges = reset ? 0 : n_edges + 1;
    q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle, away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      qe_t e;
      e = q.pop_front();
      check("dut_a", {ind_a, 4'(ch_a), sc_a, ft_a},
            {e.a.ind, e.a.ch[3:0], e.a.sc[1:0], e.a.ft});
      check("dut_b_inv", {ind_b, 4'(ch_b), sc_b, ft_b},
            {e.a.ind ^ 8'hFF, e.a.ch[3:0] ^ 4'hF, e.a.sc[1:0], e.a.ft});
      check("dut_c", {ind_c, 4'(ch_c), sc_c, ft_c},
            {e.c.ind, 4'(e.c.ch[2:0]), e.c.sc[1:0], e.c.ft});
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] v, input logic dp);
    wr_en = 1'b1; wr_index = idx; wr_value = v; wr_dp = dp;
    cyc(1);
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_index = '0; wr_value = '0; wr_dp = 1'b0;
    clear = 1'b0; blank_lz = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(40);
    // Mixed values with a decimal point
    wr(2'd0, 4'h5, 1'b1);
    wr(2'd2, 4'hA, 1'b0);
    wr(2'd3, 4'hF, 1'b0);
    cyc(40);
    // Leading-zero blanking, then a high digit un-blanks the middle
    clear = 1'b1; cyc(1); clear = 1'b0;
    wr(2'd1, 4'h7, 1'b0);
    blank_lz = 1'b1;
    cyc(40);
    wr(2'd3, 4'h1, 1'b0);
    cyc(40);
    // Clear beats a simultaneous write; index 3 is out of range for the 3-digit DUT
    clear = 1'b1; wr(2'd0, 4'h9, 1'b0); clear = 1'b0;
    cyc(10);
    wr(2'd3, 4'h8, 1'b1);
    cyc(20);
    // Reset in the middle of a slot
    reset = 1'b1; cyc(3); reset = 1'b0;
    cyc(10);
    reset = 1'b1; cyc(1); reset = 1'b0;
    wr(2'd0, 4'h8, 1'b0);
    cyc(20);
    // Randomized phase
    for (int i = 0; i < 800; i++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_index = 2'($urandom_range(0, 3));
      wr_value = 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 40) == 0);
      reset    = ($urandom_range(0, 120) == 0);
      if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
      cyc(1);
    end
    wr_en = 1'b0; clear = 1'b0; reset = 1'b0;
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
